// File: rtl/div_up_pkg.sv
// Shared ALU package: default operand width and the divider state encoding.
package div_up_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    typedef logic [1:0] div_state_t;

    localparam div_state_t IDLE = 2'd0;
    localparam div_state_t RUN  = 2'd1;
    localparam div_state_t DONE = 2'd2;

endpackage

// File: rtl/div_up.sv
// Unsigned multi-cycle restoring divider: one quotient bit per clock, MSB first,
// with a single-cycle done pulse and a divide-by-zero shortcut.
module div_up
    import div_up_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] acc_data,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] quot_out,
    output logic [WIDTH-1:0] rem_out,
    output logic             dz_div,
    output logic             busy,
    output logic             done
);

    localparam int unsigned        CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] shq_q, shq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   shifted;
    logic             sub_ok;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             unused_prem_msb;

    // After every step the partial remainder is below the divisor, so its MSB
    // is always zero and is not carried into the next shift.
    assign unused_prem_msb = prem_q[WIDTH];

    always_comb begin
        shifted  = {prem_q[WIDTH-1:0], shq_q[WIDTH-1]};
        sub_ok   = shifted >= {1'b0, dvs_q};
        step_rem = sub_ok ? (shifted - {1'b0, dvs_q}) : shifted;
        step_quo = {shq_q[WIDTH-2:0], sub_ok};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        shq_d   = shq_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d  = rd_data;
                    shq_d  = acc_data;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (rd_data == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = acc_data;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        dz_d    = 1'b0;
                    end
                end
            end
            RUN: begin
                prem_d = step_rem;
                shq_d  = step_quo;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    quot_d  = step_quo;
                    rem_d   = step_rem[WIDTH-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            shq_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            shq_q   <= shq_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign quot_out = quot_q;
    assign rem_out  = rem_q;
    assign dz_div   = dz_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule
